// File: rtl/axis_pipe_reg.sv
// axis_pipe_reg: AXI-Stream register chain with valid/ready backpressure, bubble collapsing and flush.
// Define AXIS_PIPE_REG_SKID_EN to add a one-entry skid buffer that registers s_axis_tready_o.
module axis_pipe_reg #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 2
) (
  input  logic                       clk_i,
  input  logic                       arstn_i,
  input  logic                       flush_i,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata_i,
  input  logic                       s_axis_tlast_i,
  input  logic                       s_axis_tvalid_i,
  output logic                       s_axis_tready_o,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata_o,
  output logic                       m_axis_tlast_o,
  output logic                       m_axis_tvalid_o,
  input  logic                       m_axis_tready_i,
  output logic [$clog2(DEPTH+2)-1:0] occupancy_o
);
  localparam int OW = $clog2(DEPTH+2);
  if (DEPTH < 1) begin : g_depth_check
    $error("axis_pipe_reg: DEPTH must be >= 1");
  end
  logic [DEPTH-1:0]      v_q, v_d, l_q, l_d, adv;
  logic [DATA_WIDTH-1:0] d_q [DEPTH];
  logic [DATA_WIDTH-1:0] d_d [DEPTH];
  logic [DATA_WIDTH-1:0] in_d, u_d;
  logic                  in_v, in_l, u_v, u_l, skid_v_d;
  logic [OW-1:0]         occ_q, occ_d;
  // A stage may load when it is empty or the stage ahead is moving on.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = m_axis_tready_i | ~v_q[DEPTH-1];
    for (int k = DEPTH-2; k >= 0; k--) adv[k] = ~v_q[k] | adv[k+1];
  end
  always_comb begin
    v_d = v_q;
    l_d = l_q;
    d_d = d_q;
    u_v = 1'b0;
    u_l = 1'b0;
    u_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      u_v = k == 0 ? in_v : v_q[k > 0 ? k-1 : 0];
      u_l = k == 0 ? in_l : l_q[k > 0 ? k-1 : 0];
      u_d = k == 0 ? in_d : d_q[k > 0 ? k-1 : 0];
      if (adv[k] && !flush_i) begin
        v_d[k] = u_v;
        if (u_v) begin
          d_d[k] = u_d;
          l_d[k] = u_l;
        end
      end
    end
    if (flush_i) v_d = '0;
    occ_d = OW'($countones(v_d)) + OW'(skid_v_d);
  end
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      v_q   <= '0;
      l_q   <= '0;
      d_q   <= '{default: '0};
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      l_q   <= l_d;
      d_q   <= d_d;
      occ_q <= occ_d;
    end
  end
`ifdef AXIS_PIPE_REG_SKID_EN
  logic                  skid_v_q, skid_l_q, rdy_q, acc;
  logic [DATA_WIDTH-1:0] skid_d_q;
  // Ready comes from a flop, so a stalled stage 0 parks the beat accepted this cycle in skid.
  assign s_axis_tready_o = rdy_q & ~flush_i;
  assign acc             = s_axis_tvalid_i & s_axis_tready_o;
  assign in_v            = skid_v_q | acc;
  assign in_d            = skid_v_q ? skid_d_q : s_axis_tdata_i;
  assign in_l            = skid_v_q ? skid_l_q : s_axis_tlast_i;
  assign skid_v_d        = ~flush_i & in_v & ~adv[0];
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      skid_v_q <= 1'b0;
      skid_l_q <= 1'b0;
      skid_d_q <= '0;
      rdy_q    <= 1'b1;
    end else begin
      skid_v_q <= skid_v_d;
      rdy_q    <= ~skid_v_d & ~flush_i;
      if (acc) begin
        skid_d_q <= s_axis_tdata_i;
        skid_l_q <= s_axis_tlast_i;
      end
    end
  end
`else
  assign s_axis_tready_o = adv[0] & ~flush_i;
  assign in_v            = s_axis_tvalid_i;
  assign in_d            = s_axis_tdata_i;
  assign in_l            = s_axis_tlast_i;
  assign skid_v_d        = 1'b0;
`endif
  assign m_axis_tvalid_o = v_q[DEPTH-1];
  assign m_axis_tdata_o  = d_q[DEPTH-1];
  assign m_axis_tlast_o  = l_q[DEPTH-1];
  assign occupancy_o     = occ_q;
endmodule

// File: tb/tb_axis_pipe_reg.sv
// tb_axis_pipe_reg: directed and random stimulus against a beat-position queue model of the pipe.
// Each beat moves one slot per cycle unless blocked by the beat ahead; the head leaves on tready.
module tb_axis_pipe_reg;
  localparam int DW = 16;
  localparam int D  = 3;
  localparam int OW = $clog2(D+2);
  logic          clk_i = 1'b0, arstn_i = 1'b0, flush_i = 1'b0;
  logic          sv = 1'b0, sl = 1'b0, mr = 1'b0;
  logic [DW-1:0] sd = '0;
  logic          s_rdy, m_v, m_l;
  logic [DW-1:0] m_d;
  logic [OW-1:0] occ;
  int            checks = 0, errors = 0, cyc = 0, e1 = 0, idx = 0;
  bit            chk_en = 1'b0, acc_last = 1'b0, ev;
  logic [DW-1:0] md[$];
  logic          ml[$];
  int            mp[$];
  logic [DW-1:0] got_d[$];
  logic          got_l[$];
  int            got_c[$];
  always #5 clk_i = ~clk_i;
  axis_pipe_reg #(.DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .flush_i(flush_i),
    .s_axis_tdata_i(sd), .s_axis_tlast_i(sl), .s_axis_tvalid_i(sv), .s_axis_tready_o(s_rdy),
    .m_axis_tdata_o(m_d), .m_axis_tlast_o(m_l), .m_axis_tvalid_o(m_v), .m_axis_tready_i(mr),
    .occupancy_o(occ)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Slot of the last beat after this cycle's moves (D when the pipe ends up empty).
  function automatic int tail_after(input bit rdy);
    int lim = D;
    int s = (md.size() > 0 && mp[0] == D-1 && rdy) ? 1 : 0;
    for (int i = s; i < mp.size(); i++) lim = (mp[i] + 1 < lim - 1) ? mp[i] + 1 : lim - 1;
    return lim;
  endfunction
  task automatic model_clear();
    md.delete();
    ml.delete();
    mp.delete();
  endtask
  task automatic model_step();
    bit acc;
    int lim;
    if (flush_i) begin
      model_clear();
      return;
    end
    acc = sv && tail_after(mr) >= 1;
    if (md.size() > 0 && mp[0] == D-1 && mr) begin
      void'(md.pop_front());
      void'(ml.pop_front());
      void'(mp.pop_front());
    end
    lim = D;
    foreach (mp[i]) begin
      mp[i] = (mp[i] + 1 < lim - 1) ? mp[i] + 1 : lim - 1;
      lim = mp[i];
    end
    if (acc) begin
      md.push_back(sd);
      ml.push_back(sl);
      mp.push_back(0);
    end
  endtask
  task automatic tick();
    @(negedge clk_i);
    acc_last = sv && s_rdy;
    @(posedge clk_i);
    cyc++;
    if (!arstn_i) model_clear();
    else model_step();
    #1;
  endtask
  task automatic got_clear();
    got_d.delete();
    got_l.delete();
    got_c.delete();
  endtask
  always @(negedge clk_i) begin
    if (chk_en && arstn_i) begin
      ev = md.size() > 0 && mp[0] == D-1;
      chk("m_tvalid", int'(m_v), int'(ev));
      if (ev) begin
        chk("m_tdata", int'(m_d), int'(md[0]));
        chk("m_tlast", int'(m_l), int'(ml[0]));
      end
      chk("s_tready", int'(s_rdy), int'(!flush_i && tail_after(mr) >= 1));
      chk("occupancy", int'(occ), md.size());
      if (m_v && mr && !flush_i) begin
        got_d.push_back(m_d);
        got_l.push_back(m_l);
        got_c.push_back(cyc);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) tick();
    #3 arstn_i = 1'b1;
    chk_en = 1'b1;
    tick();
    chk("reset_tvalid", int'(m_v), 0);
    chk("reset_occ", int'(occ), 0);
    chk("reset_tready", int'(s_rdy), 1);
    chk("reset_tdata", int'(m_d), 0);
    chk("reset_tlast", int'(m_l), 0);
    mr = 1'b1;
    got_clear();
    for (int i = 1; i <= 8; i++) begin
      sv = 1'b1;
      sd = DW'(i);
      sl = i == 8;
      tick();
      if (i == 1) e1 = cyc;
    end
    sv = 1'b0;
    sl = 1'b0;
    repeat (5) tick();
    chk("stream_count", got_d.size(), 8);
    if (got_c.size() > 0) chk("stream_latency", got_c[0] - e1, 2);
    for (int i = 0; i < got_d.size() && i < 8; i++) begin
      chk("stream_data", int'(got_d[i]), i + 1);
      chk("stream_tlast", int'(got_l[i]), int'(i == 7));
      chk("stream_gap", got_c[i] - got_c[0], i);
    end
    mr = 1'b0;
    got_clear();
    idx = 0;
    for (int n = 0; n < 8; n++) begin
      sv = 1'b1;
      sd = DW'(32'h00A0 + idx);
      tick();
      if (acc_last) idx++;
    end
    chk("bp_accepted", idx, 3);
    chk("bp_tready", int'(s_rdy), 0);
    chk("bp_occ", int'(occ), 3);
    chk("bp_tdata_hold", int'(m_d), 16'h00A0);
    mr = 1'b1;
    for (int n = 0; n < 20 && idx < 6; n++) begin
      sv = 1'b1;
      sd = DW'(32'h00A0 + idx);
      tick();
      if (acc_last) idx++;
    end
    sv = 1'b0;
    repeat (6) tick();
    chk("bp_drain_count", got_d.size(), 6);
    for (int i = 0; i < got_d.size() && i < 6; i++) chk("bp_drain_data", int'(got_d[i]), 16'h00A0 + i);
    mr = 1'b0;
    got_clear();
    sv = 1'b1;
    sd = 16'h1234;
    tick();
    chk("bub_acc1", int'(acc_last), 1);
    sv = 1'b0;
    repeat (4) tick();
    chk("bub_occ1", int'(occ), 1);
    chk("bub_tvalid", int'(m_v), 1);
    chk("bub_tdata", int'(m_d), 16'h1234);
    sv = 1'b1;
    sd = 16'h5678;
    tick();
    chk("bub_acc2", int'(acc_last), 1);
    sv = 1'b0;
    tick();
    chk("bub_occ2", int'(occ), 2);
    chk("bub_head_hold", int'(m_d), 16'h1234);
    mr = 1'b1;
    repeat (5) tick();
    chk("bub_count", got_d.size(), 2);
    if (got_d.size() == 2) begin
      chk("bub_out0", int'(got_d[0]), 16'h1234);
      chk("bub_out1", int'(got_d[1]), 16'h5678);
    end
    mr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sv = 1'b1;
      sd = DW'(32'h00C0 + i);
      tick();
    end
    sv = 1'b0;
    chk("flush_pre_occ", int'(occ), 3);
    got_clear();
    sv = 1'b1;
    sd = 16'h00CC;
    mr = 1'b1;
    flush_i = 1'b1;
    #1;
    chk("flush_s_tready", int'(s_rdy), 0);
    tick();
    chk("flush_no_accept", int'(acc_last), 0);
    flush_i = 1'b0;
    sv = 1'b0;
    chk("flush_occ", int'(occ), 0);
    chk("flush_tvalid", int'(m_v), 0);
    repeat (3) tick();
    chk("flush_no_output", got_d.size(), 0);
    mr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sv = 1'b1;
      sd = DW'(32'h00C8 + i);
      sl = i == 0;
      tick();
    end
    sv = 1'b0;
    sl = 1'b0;
    chk("arst_pre_occ", int'(occ), 3);
    #2;
    chk_en = 1'b0;
    arstn_i = 1'b0;
    #1;
    chk("arst_tvalid", int'(m_v), 0);
    chk("arst_tdata", int'(m_d), 0);
    chk("arst_tlast", int'(m_l), 0);
    chk("arst_occ", int'(occ), 0);
    chk("arst_tready", int'(s_rdy), 1);
    model_clear();
    repeat (2) tick();
    arstn_i = 1'b1;
    chk_en = 1'b1;
    got_clear();
    mr = 1'b1;
    sv = 1'b1;
    sd = 16'h0BEE;
    sl = 1'b1;
    tick();
    sv = 1'b0;
    sl = 1'b0;
    repeat (5) tick();
    chk("arst_restart_count", got_d.size(), 1);
    if (got_d.size() > 0) begin
      chk("arst_restart_data", int'(got_d[0]), 16'h0BEE);
      chk("arst_restart_tlast", int'(got_l[0]), 1);
    end
    for (int n = 0; n < 3000; n++) begin
      sv      = $urandom_range(0, 3) != 0;
      sd      = DW'($urandom);
      sl      = $urandom_range(0, 7) == 0;
      mr      = $urandom_range(0, 99) < (((n / 500) % 2) != 0 ? 30 : 85);
      flush_i = $urandom_range(0, 60) == 0;
      tick();
    end
    flush_i = 1'b0;
    sv = 1'b0;
    mr = 1'b1;
    repeat (6) tick();
    chk("final_occ", int'(occ), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
